// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - reset and clock-enable sequencer for the ADC datapath domains
// Synchronizes board reset release, staggers per-domain reset/clock-enable release, services soft reset.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS    = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_rst_req,
  output logic                   soft_rst_ack,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic [NUM_DOMAINS-1:0] dom_clk_en,
  output logic                   ready
);

  localparam logic [2:0] ST_RESET   = 3'd0;
  localparam logic [2:0] ST_HOLD    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_RUN     = 3'd3;
  localparam logic [2:0] ST_QUIESCE = 3'd4;

  localparam logic [CNT_W-1:0]       HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]       QUIESCE_LAST = CNT_W'(1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE      = NUM_DOMAINS'(1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL      = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rst_sync;
  logic                   rst_sync_next;
  logic [2:0]             state;
  logic [CNT_W-1:0]       cnt;

  assign rst_sync      = sync[SYNC_STAGES-1];
  assign rst_sync_next = sync[SYNC_STAGES-2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // The FSM leaves RESET on the same edge the synchronizer output rises, so it looks one stage ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_RESET;
      cnt          <= '0;
      dom_rst_n    <= '0;
      dom_clk_en   <= '0;
      ready        <= 1'b0;
      soft_rst_ack <= 1'b0;
    end else begin
      soft_rst_ack <= 1'b0;
      case (state)
        ST_RESET: begin
          if (rst_sync_next && !rst_sync) begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            dom_rst_n <= DOM_ONE;
            cnt       <= '0;
            state     <= ST_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          // Resets only ever rise here, so each enable trails its reset by exactly one edge.
          dom_clk_en <= dom_rst_n;
          if (dom_rst_n != DOM_ALL) begin
            if (cnt == STAGGER_LAST) begin
              dom_rst_n <= (dom_rst_n << 1) | DOM_ONE;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (dom_clk_en[NUM_DOMAINS-1]) begin
            ready <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (soft_rst_req) begin
            dom_clk_en <= '0;
            ready      <= 1'b0;
            cnt        <= '0;
            state      <= ST_QUIESCE;
          end
        end
        ST_QUIESCE: begin
          // Clocks have been gated for two edges before the domain resets drop.
          if (cnt == QUIESCE_LAST) begin
            dom_rst_n    <= '0;
            soft_rst_ack <= 1'b1;
            cnt          <= '0;
            state        <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb/tb_rst_seq_ctrl.sv - scoreboard bench for rst_seq_ctrl
// Default instance is event-checked; a minimal-parameter instance is timing- and invariant-checked.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       soft_rst_ack;
  logic [3:0] dom_rst_n;
  logic [3:0] dom_clk_en;
  logic       ready;
  logic       ack_s;
  logic [0:0] rstn_s;
  logic [0:0] en_s;
  logic       ready_s;

  int cyc = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int         cyc;
    logic [9:0] val;
  } ev_t;

  ev_t exp_q[$];

  // Hand-computed power-on event table for the default parameters: {ack, ready, en[3:0], rstn[3:0]}.
  int         seq_off [9] = '{16, 17, 20, 21, 24, 25, 28, 29, 30};
  logic [9:0] seq_val [9] = '{10'b00_0000_0001, 10'b00_0001_0001, 10'b00_0001_0011,
                              10'b00_0011_0011, 10'b00_0011_0111, 10'b00_0111_0111,
                              10'b00_0111_1111, 10'b00_1111_1111, 10'b01_1111_1111};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rst_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .dom_rst_n    (dom_rst_n),
    .dom_clk_en   (dom_clk_en),
    .ready        (ready)
  );

  rst_seq_ctrl #(
    .NUM_DOMAINS    (1),
    .SYNC_STAGES    (2),
    .HOLD_CYCLES    (1),
    .STAGGER_CYCLES (1),
    .CNT_W          (4)
  ) dut_small (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (ack_s),
    .dom_rst_n    (rstn_s),
    .dom_clk_en   (en_s),
    .ready        (ready_s)
  );

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] req);
    total++;
    if (got === req) passed++;
    else $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, req);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_ev(input int c, input logic [9:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input int e0, input int limit);
    for (int i = 0; i < 9; i++)
      if (e0 + seq_off[i] <= limit) push_ev(e0 + seq_off[i], seq_val[i]);
  endtask

  task automatic push_quiesce(input int s);
    push_ev(s,     10'b00_0000_1111);
    push_ev(s + 2, 10'b10_0000_0000);
    push_ev(s + 3, 10'b00_0000_0000);
  endtask

  task automatic drain(input string name, input int limit);
    while (exp_q.size() != 0 && cyc < limit) begin
      @(posedge clk);
      #2;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL %s_timeout cyc=%0d pending_events=%0d required=0", name, cyc, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Every change of the observed output vector must match the next queued expected event.
  task automatic monitor();
    logic [9:0] cur;
    logic [9:0] prev;
    ev_t        ev;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {soft_rst_ack, ready, dom_clk_en, dom_rst_n};
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event cyc=%0d got=%b required=no_change", cyc, cur);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc == cyc && ev.val === cur) passed++;
          else $display("FAIL event cyc=%0d got=%b required_cyc=%0d required=%b", cyc, cur, ev.cyc, ev.val);
        end
        prev = cur;
      end
      total++;
      if (((dom_clk_en & ~dom_rst_n) == 4'b0000) &&
          ((dom_rst_n[3:1] & ~dom_rst_n[2:0]) == 3'b000) &&
          (!ready || (&dom_clk_en)) &&
          (!en_s[0] || rstn_s[0]) &&
          (!ready_s || en_s[0]))
        passed++;
      else
        $display("FAIL invariants cyc=%0d got rstn=%b en=%b ready=%b small=%b%b%b required=consistent",
                 cyc, dom_rst_n, dom_clk_en, ready, rstn_s, en_s, ready_s);
    end
  endtask

  initial begin
    int c;
    int e0;
    int s1;
    int s2;
    fork
      monitor();
    join_none

    step_to(3);
    chk("reset_outputs", {soft_rst_ack, ready, dom_clk_en, dom_rst_n}, 10'd0);
    chk("reset_outputs_small", 10'({ack_s, ready_s, en_s, rstn_s}), 10'd0);

    // Power-on with default timing; small instance checked edge by edge.
    c = cyc;
    rst = 1'b1;
    e0 = c + 2;
    push_seq(e0, e0 + 100);
    step_to(e0);
    chk("small_e0", 10'({ready_s, en_s, rstn_s}), 10'b000);
    step_to(e0 + 1);
    chk("small_e0p1", 10'({ready_s, en_s, rstn_s}), 10'b001);
    step_to(e0 + 2);
    chk("small_e0p2", 10'({ready_s, en_s, rstn_s}), 10'b011);
    step_to(e0 + 3);
    chk("small_e0p3", 10'({ready_s, en_s, rstn_s}), 10'b111);
    drain("power_on", e0 + 40);

    // One-cycle soft reset request.
    c = cyc;
    soft_rst_req = 1'b1;
    s1 = c + 1;
    push_quiesce(s1);
    push_seq(s1 + 2, s1 + 100);
    step_to(c + 1);
    soft_rst_req = 1'b0;
    drain("soft_reset", s1 + 40);

    // Async reset from RUN, then mid-RELEASE, with a sub-cycle glitch restarting the sequence.
    c = cyc;
    push_ev(c, 10'd0);
    rst = 1'b0;
    #1;
    chk("async_clear_run", {soft_rst_ack, ready, dom_clk_en, dom_rst_n}, 10'd0);
    step_to(c + 3);
    rst = 1'b1;
    e0 = c + 5;
    push_seq(e0, e0 + 21);
    step_to(e0 + 22);
    chk("pre_drop_release", {soft_rst_ack, ready, dom_clk_en, dom_rst_n}, 10'b00_0011_0011);
    push_ev(e0 + 22, 10'd0);
    rst = 1'b0;
    #1;
    chk("async_clear_release", {soft_rst_ack, ready, dom_clk_en, dom_rst_n}, 10'd0);
    chk("async_clear_small", 10'({ack_s, ready_s, en_s, rstn_s}), 10'd0);
    #1;
    rst = 1'b1;
    e0 = e0 + 24;
    push_seq(e0, e0 + 100);
    drain("glitch_restart", e0 + 40);

    // Held request: two back-to-back soft resets with one ready cycle between.
    c = cyc;
    soft_rst_req = 1'b1;
    s1 = c + 1;
    push_quiesce(s1);
    push_seq(s1 + 2, s1 + 100);
    s2 = s1 + 33;
    push_quiesce(s2);
    push_seq(s2 + 2, s2 + 100);
    step_to(s2 + 5);
    soft_rst_req = 1'b0;
    drain("held_request", s2 + 40);

    // Request raised only during HOLD must be ignored.
    c = cyc;
    push_ev(c, 10'd0);
    rst = 1'b0;
    step_to(c + 2);
    rst = 1'b1;
    e0 = c + 4;
    push_seq(e0, e0 + 100);
    step_to(e0 + 3);
    soft_rst_req = 1'b1;
    step_to(e0 + 10);
    soft_rst_req = 1'b0;
    drain("req_outside_run", e0 + 40);

    step_to(cyc + 6);
    chk("final_run", {soft_rst_ack, ready, dom_clk_en, dom_rst_n}, 10'b01_1111_1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset and clock-enable sequencer for the digital ADC datapath.
- Synchronizes deassertion of the board-level asynchronous reset.
- Holds all downstream domains in reset for a fixed count, then releases them in staggered order (domain 0 first) and enables each domain's clock one cycle after its reset is released.
- Services a soft-reset request handshake from the control logic.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset/clock-enable domains (>=1)
- SYNC_STAGES, 2, reset-deassertion synchronizer depth (>=2)
- HOLD_CYCLES, 16, cycles all domains stay in reset after the synchronized release (>=1)
- STAGGER_CYCLES, 4, cycles between consecutive domain reset releases (>=1)
- CNT_W, 8, width of the internal counter; must hold max(HOLD_CYCLES, STAGGER_CYCLES)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- soft_rst_req  input  1  level request for a soft reset; sampled only in RUN
- soft_rst_ack  output  1  one-cycle pulse when soft reset asserts domain resets
- dom_rst_n  output  NUM_DOMAINS  per-domain active-low reset
- dom_clk_en  output  NUM_DOMAINS  per-domain clock enable
- ready  output  1  high while all domains are running (state RUN)

Behaviour:
- rst low:
  - asynchronously clears every flop.
  - dom_rst_n=0, dom_clk_en=0, ready=0, soft_rst_ack=0, state=RESET.
  - This applies at any time, including mid-sequence or mid-soft-reset.
- Synchronizer:
  - Chain of SYNC_STAGES flops, cleared asynchronously by rst, shifting in 1.
  - rst_sync goes high at the SYNC_STAGES-th rising edge after rst rises. Call that edge E0.
- State machine, all outputs registered:
  - RESET -> HOLD at E0; counter cleared.
  - HOLD: counter increments each cycle. After HOLD_CYCLES cycles (edge E0+HOLD_CYCLES), dom_rst_n[0] rises and the state goes to RELEASE.
  - RELEASE:
    - dom_rst_n[i] rises at edge E0+HOLD_CYCLES+i*STAGGER_CYCLES.
    - dom_clk_en[i] rises exactly one edge after dom_rst_n[i].
    - After dom_clk_en[NUM_DOMAINS-1] rises, the next edge sets ready=1 and the state goes to RUN.
    - With defaults, ready rises at E0+30.
  - RUN: all dom_rst_n=1, all dom_clk_en=1, ready=1. soft_rst_req=1 sampled at edge S causes the QUIESCE transition below.
  - QUIESCE:
    - At edge S: all dom_clk_en=0 and ready=0.
    - At edge S+2: all dom_rst_n=0, soft_rst_ack=1 for exactly one cycle, counter cleared, state -> HOLD.
    - Edge S+2 then takes the role of E0: dom_rst_n[0] rises at S+2+HOLD_CYCLES.
- Monotonicity:
  - dom_rst_n bits only rise in ascending index order and only fall together.
  - dom_clk_en[i] is never 1 while dom_rst_n[i] is 0.
- soft_rst_req:
  - Ignored outside RUN; no queuing.
  - It is a level request. If it is still high on re-entry to RUN, a new soft reset starts at that edge.
  - The requester drops it after seeing the ack.
- NUM_DOMAINS=1: RELEASE collapses to a single release; ready at E0+HOLD_CYCLES+2.
- Glitch on rst shorter than one clock: outputs still clear asynchronously; the full sequence restarts from the synchronizer.
- ready is never high in any state other than RUN.

Test Plan:
1. Power-on, defaults: rst low 3 cycles, then high → dom_rst_n[0..3] rise at E0+16/20/24/28, dom_clk_en[0..3] at E0+17/21/25/29, ready at E0+30, E0 = 2nd edge after release.
2. Soft reset: in RUN, pulse soft_rst_req for 1 cycle at edge S → dom_clk_en=0 and ready=0 at S; dom_rst_n=0 and soft_rst_ack=1 at S+2 for one cycle; dom_rst_n[0] rises at S+18; ready at S+32.
3. Async reset mid-RELEASE: drop rst at E0+22 (domains 0,1 released) → all outputs 0 immediately with no clock edge; on release, the sequence restarts with identical timing to scenario 1.
4. Held request: keep soft_rst_req high continuously → soft reset repeats each time RUN is entered, with exactly one ack pulse per cycle of the sequence and ready high for one cycle between.
5. Request outside RUN: assert soft_rst_req during HOLD and drop it before RUN → no ack, timing identical to scenario 1.
6. Invariant checker over all scenarios plus NUM_DOMAINS=1, HOLD_CYCLES=1, STAGGER_CYCLES=1:
   - dom_clk_en[i] implies dom_rst_n[i].
   - dom_rst_n[i] implies dom_rst_n[i-1].
   - ready implies all enables are high.
